// File: rtl/obi_hetic_pkg.sv
// Shared types and field layout for the OBI-mapped interrupt controller's
// per-line configuration half-word.
package obi_hetic_pkg;

  localparam int unsigned NrIrqPrios = 32;
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios);

  localparam int unsigned IeBit      = 0;
  localparam int unsigned IpBit      = 1;
  localparam int unsigned TrigLsb    = 2;
  localparam int unsigned HetiBit    = 4;
  localparam int unsigned NestBit    = 5;
  localparam int unsigned FlagsWidth = 6;
  localparam int unsigned PrioOffset = 8;
  localparam int unsigned HalfShift  = 16;

  typedef struct packed {
    logic [PrioWidth-1:0] prio;
    logic                 nest;
    logic                 heti;
    logic [1:0]           trig;
    logic                 ip;
    logic                 ie;
  } irq_line_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } mgr_state_e;

endpackage

// File: rtl/obi_bus.sv
// Minimal single-beat OBI bus bundle with manager and subordinate views.
interface OBI_BUS;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport Manager (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport Subordinate (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/hetic_line_codec.sv
// Packs a line configuration into the controller's half-word-per-line word
// layout and unpacks a read word back into a line configuration.
module hetic_line_codec
  import obi_hetic_pkg::*;
(
  input  logic        wr_odd,
  input  logic        rd_odd,
  input  logic        we,
  input  logic        wr_prio,
  input  logic        wr_flags,
  input  irq_line_t   cfg,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  input  logic [31:0] rdata,
  output irq_line_t   rd_cfg
);

  logic [15:0] wr_half;
  logic [15:0] rd_half;
  logic [1:0]  half_be;
  logic        unused_rd;

  // Fields not selected for writing stay zero so the bus never carries stale data.
  always_comb begin
    wr_half = '0;
    half_be = 2'b11;
    if (we) begin
      half_be = {wr_prio, wr_flags};
      if (wr_flags) begin
        wr_half[IeBit]        = cfg.ie;
        wr_half[IpBit]        = cfg.ip;
        wr_half[TrigLsb +: 2] = cfg.trig;
        wr_half[HetiBit]      = cfg.heti;
        wr_half[NestBit]      = cfg.nest;
      end
      if (wr_prio) begin
        wr_half[PrioOffset +: PrioWidth] = cfg.prio;
      end
    end
    wdata = wr_odd ? {wr_half, 16'h0000} : {16'h0000, wr_half};
    be    = wr_odd ? {half_be, 2'b00} : {2'b00, half_be};
  end

  always_comb begin
    rd_half     = rd_odd ? rdata[HalfShift +: 16] : rdata[15:0];
    rd_cfg      = '0;
    rd_cfg.ie   = rd_half[IeBit];
    rd_cfg.ip   = rd_half[IpBit];
    rd_cfg.trig = rd_half[TrigLsb +: 2];
    rd_cfg.heti = rd_half[HetiBit];
    rd_cfg.nest = rd_half[NestBit];
    rd_cfg.prio = rd_half[PrioOffset +: PrioWidth];
  end

  assign unused_rd = ^{rd_half[7:FlagsWidth], rd_half[15:PrioOffset+PrioWidth]};

endmodule

// File: rtl/obi_hetic_cfg_mgr.sv
// OBI manager that programs/reads interrupt-line configuration, one transaction
// outstanding. Define OBI_HETIC_CFG_MGR_TIMEOUT_EN to bound the wait for rvalid.
module obi_hetic_cfg_mgr
  import obi_hetic_pkg::*;
#(
  parameter int unsigned  NrIrqLines    = 64,
  parameter logic [31:0]  BaseAddr      = 32'h0,
  parameter int unsigned  TimeoutCycles = 255,
  localparam int unsigned IrqWidth      = $clog2(NrIrqLines)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  OBI_BUS.Manager             obi_mgr,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [IrqWidth-1:0] cmd_line_i,
  input  logic                cmd_wr_prio_i,
  input  logic                cmd_wr_flags_i,
  input  irq_line_t           cmd_cfg_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output irq_line_t           rsp_cfg_o,
  output logic                rsp_err_o
);

  mgr_state_e  state_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        odd_q;
  logic        rsp_valid_q;
  irq_line_t   rsp_cfg_q;
  logic [31:0] pack_wdata;
  logic [3:0]  pack_be;
  irq_line_t   unpack_cfg;

`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
  localparam int unsigned TimeoutW = $clog2(TimeoutCycles + 1);
  logic [TimeoutW-1:0] wait_cnt_q;
  logic                rsp_err_q;
  assign rsp_err_o = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TimeoutCycles;
  assign rsp_err_o      = 1'b0;
`endif

  hetic_line_codec u_codec (
    .wr_odd   (cmd_line_i[0]),
    .rd_odd   (odd_q),
    .we       (cmd_we_i),
    .wr_prio  (cmd_wr_prio_i),
    .wr_flags (cmd_wr_flags_i),
    .cfg      (cmd_cfg_i),
    .wdata    (pack_wdata),
    .be       (pack_be),
    .rdata    (obi_mgr.rdata),
    .rd_cfg   (unpack_cfg)
  );

  assign cmd_ready_o   = (state_q == IDLE) && !rst_i;
  assign obi_mgr.req   = req_q;
  assign obi_mgr.addr  = addr_q;
  assign obi_mgr.we    = we_q;
  assign obi_mgr.be    = be_q;
  assign obi_mgr.wdata = wdata_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_cfg_o     = rsp_cfg_q;

  // Bus request fields are captured once at accept and held until the grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      odd_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_cfg_q   <= '0;
`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            odd_q <= cmd_line_i[0];
            if (cmd_we_i && !cmd_wr_prio_i && !cmd_wr_flags_i) begin
              rsp_valid_q <= 1'b1;
              rsp_cfg_q   <= '0;
`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
              rsp_err_q   <= 1'b0;
`endif
              state_q     <= RSP;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= BaseAddr + 32'({cmd_line_i[IrqWidth-1:1], 2'b00});
              we_q    <= cmd_we_i;
              be_q    <= pack_be;
              wdata_q <= pack_wdata;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (obi_mgr.gnt) begin
            req_q   <= 1'b0;
`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A late rvalid on the terminal count still counts as a good response.
          if (obi_mgr.rvalid) begin
            rsp_valid_q <= 1'b1;
            rsp_cfg_q   <= we_q ? '0 : unpack_cfg;
`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= RSP;
          end
`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
          else if (wait_cnt_q == TimeoutW'(TimeoutCycles - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_cfg_q   <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= RSP;
          end else begin
            wait_cnt_q <= wait_cnt_q + TimeoutW'(1);
          end
`endif
        end
        RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_hetic_cfg_mgr.sv
// Scoreboard bench for obi_hetic_cfg_mgr; the bench plays the OBI subordinate.
// Timeout scenario is only exercised when OBI_HETIC_CFG_MGR_TIMEOUT_EN is defined.
module tb_obi_hetic_cfg_mgr;
  import obi_hetic_pkg::*;

`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
  localparam int unsigned TbTimeout = 4;
`else
  localparam int unsigned TbTimeout = 255;
`endif
  localparam logic [31:0] TbBase = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    irq_line_t cfg;
    logic      err;
  } rsp_t;

  logic      clk = 1'b0;
  logic      rst;
  logic      cmd_valid;
  logic      cmd_ready;
  logic      cmd_we;
  logic [5:0] cmd_line;
  logic      cmd_wr_prio;
  logic      cmd_wr_flags;
  irq_line_t cmd_cfg;
  logic      rsp_valid;
  logic      rsp_ready;
  irq_line_t rsp_cfg;
  logic      rsp_err;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  OBI_BUS obi ();

  always #5 clk = ~clk;

  always @(negedge clk) if (obi.req === 1'b1) req_cycles++;

  obi_hetic_cfg_mgr #(
    .NrIrqLines    (64),
    .BaseAddr      (TbBase),
    .TimeoutCycles (TbTimeout)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .obi_mgr        (obi),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_we_i       (cmd_we),
    .cmd_line_i     (cmd_line),
    .cmd_wr_prio_i  (cmd_wr_prio),
    .cmd_wr_flags_i (cmd_wr_flags),
    .cmd_cfg_i      (cmd_cfg),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_cfg_o      (rsp_cfg),
    .rsp_err_o      (rsp_err)
  );

  function automatic irq_line_t mk_cfg(input logic [4:0] prio, input logic nest, input logic heti,
                                       input logic [1:0] trig, input logic ip, input logic ie);
    irq_line_t c;
    c.prio = prio; c.nest = nest; c.heti = heti; c.trig = trig; c.ip = ip; c.ie = ie;
    return c;
  endfunction

  // Independent reference of the controller word layout.
  function automatic bus_t model_bus(input logic we, input logic [5:0] line, input logic wp,
                                     input logic wf, input irq_line_t c);
    bus_t b;
    logic [15:0] h;
    logic [1:0]  hb;
    h  = 16'h0;
    hb = 2'b11;
    if (we) begin
      hb = {wp, wf};
      h  = {3'b000, (wp ? c.prio : 5'd0), 2'b00,
            (wf ? {c.nest, c.heti, c.trig, c.ip, c.ie} : 6'd0)};
    end
    b.addr  = TbBase + ((32'(line) >> 1) * 4);
    b.we    = we;
    b.be    = line[0] ? {hb, 2'b00} : {2'b00, hb};
    b.wdata = line[0] ? {h, 16'h0} : {16'h0, h};
    return b;
  endfunction

  function automatic rsp_t model_rsp(input logic we, input logic [5:0] line, input logic [31:0] rdata);
    rsp_t r;
    logic [15:0] h;
    h     = line[0] ? rdata[31:16] : rdata[15:0];
    r.cfg = we ? irq_line_t'(0) : irq_line_t'({h[12:8], h[5:0]});
    r.err = 1'b0;
    return r;
  endfunction

  task automatic issue(input logic we, input logic [5:0] line, input logic wp, input logic wf,
                       input irq_line_t cfg);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_we = we; cmd_line = line;
    cmd_wr_prio = wp; cmd_wr_flags = wf; cmd_cfg = cfg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic serve(input int gnt_delay, input logic [31:0] rdata);
    bus_t exp;
    if (bus_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL bus_scoreboard_empty: got 0 entries want 1");
      return;
    end
    exp = bus_q.pop_front();
    for (int i = 0; i <= gnt_delay; i++) begin
      checks++;
      if (obi.req !== 1'b1 || obi.addr !== exp.addr || obi.we !== exp.we ||
          obi.be !== exp.be || obi.wdata !== exp.wdata) begin
        errors++;
        $display("[TB] FAIL bus_req cyc%0d: got req=%b addr=%h we=%b be=%b wdata=%h want req=1 addr=%h we=%b be=%b wdata=%h",
                 i, obi.req, obi.addr, obi.we, obi.be, obi.wdata, exp.addr, exp.we, exp.be, exp.wdata);
      end
      obi.gnt = (i == gnt_delay);
      @(negedge clk);
    end
    obi.gnt = 1'b0;
    checks++;
    if (obi.req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL req_after_gnt: got %b want 0", obi.req);
    end
    obi.rvalid = 1'b1; obi.rdata = rdata;
    @(negedge clk);
    obi.rvalid = 1'b0; obi.rdata = '0;
  endtask

  task automatic check_rsp(input int hold);
    rsp_t exp;
    if (rsp_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_scoreboard_empty: got 0 entries want 1");
      return;
    end
    exp = rsp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_cfg !== exp.cfg || rsp_err !== exp.err || cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rsp cyc%0d: got valid=%b cfg=%h err=%b ready=%b want valid=1 cfg=%h err=%b ready=0",
                 i, rsp_valid, rsp_cfg, rsp_err, cmd_ready, exp.cfg, exp.err);
      end
      rsp_ready = (i == hold);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rsp_release: got valid=%b ready=%b want valid=0 ready=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || obi.req !== 1'b0 || obi.addr !== 32'h0 || obi.we !== 1'b0 ||
        obi.be !== 4'h0 || obi.wdata !== 32'h0 || rsp_valid !== 1'b0 || rsp_cfg !== irq_line_t'(0) ||
        rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got ready=%b req=%b addr=%h we=%b be=%b wdata=%h rv=%b cfg=%h err=%b want all 0",
               cmd_ready, obi.req, obi.addr, obi.we, obi.be, obi.wdata, rsp_valid, rsp_cfg, rsp_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_line6;
    bus_q.push_back('{addr: 32'h0000_000C, we: 1'b1, be: 4'b0011, wdata: 32'h0000_0509});
    rsp_q.push_back('{cfg: irq_line_t'(0), err: 1'b0});
    issue(1'b1, 6'd6, 1'b1, 1'b1, mk_cfg(5'd5, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1));
    serve(0, 32'hFFFF_FFFF);
    check_rsp(0);
  endtask

  task automatic test_read_line7;
    bus_q.push_back('{addr: 32'h0000_000C, we: 1'b0, be: 4'b1100, wdata: 32'h0});
    rsp_q.push_back('{cfg: mk_cfg(5'd31, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1), err: 1'b0});
    issue(1'b0, 6'd7, 1'b1, 1'b1, mk_cfg(5'd3, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0));
    serve(0, 32'h1F31_0000);
    check_rsp(0);
  endtask

  task automatic test_write_line3_prio;
    bus_q.push_back('{addr: 32'h0000_0004, we: 1'b1, be: 4'b1000, wdata: 32'h0900_0000});
    rsp_q.push_back('{cfg: irq_line_t'(0), err: 1'b0});
    issue(1'b1, 6'd3, 1'b1, 1'b0, mk_cfg(5'd9, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1));
    serve(0, 32'h0);
    check_rsp(0);
  endtask

  task automatic test_stall;
    bus_q.push_back('{addr: 32'h0000_0014, we: 1'b0, be: 4'b0011, wdata: 32'h0});
    rsp_q.push_back('{cfg: mk_cfg(5'd10, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0), err: 1'b0});
    issue(1'b0, 6'd10, 1'b0, 1'b0, mk_cfg(5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0));
    serve(5, 32'hABCD_0A2E);
    check_rsp(3);
  endtask

  task automatic test_skip_write;
    int req_before;
    req_before = req_cycles;
    rsp_q.push_back('{cfg: irq_line_t'(0), err: 1'b0});
    issue(1'b1, 6'd9, 1'b0, 1'b0, mk_cfg(5'd7, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1));
    check_rsp(1);
    checks++;
    if (req_cycles != req_before) begin
      errors++;
      $display("[TB] FAIL skip_no_req: got %0d req cycles want 0", req_cycles - req_before);
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++) begin
      logic        we, wp, wf;
      logic [5:0]  line;
      logic [31:0] rdata;
      irq_line_t   cfg;
      we    = 1'($urandom_range(0, 1));
      wp    = 1'($urandom_range(0, 1));
      wf    = 1'($urandom_range(0, 1));
      if (we && !wp && !wf) wf = 1'b1;
      line  = 6'($urandom_range(0, 63));
      rdata = $urandom;
      cfg   = irq_line_t'($urandom);
      bus_q.push_back(model_bus(we, line, wp, wf, cfg));
      rsp_q.push_back(model_rsp(we, line, rdata));
      issue(we, line, wp, wf, cfg);
      serve(0, rdata);
      check_rsp(0);
    end
  endtask

  task automatic test_reset_mid;
    bus_t exp;
    exp = model_bus(1'b0, 6'd2, 1'b0, 1'b0, irq_line_t'(0));
    issue(1'b0, 6'd2, 1'b0, 1'b0, irq_line_t'(0));
    checks++;
    if (obi.req !== 1'b1 || obi.addr !== exp.addr || obi.be !== exp.be) begin
      errors++;
      $display("[TB] FAIL mid_req: got req=%b addr=%h be=%b want req=1 addr=%h be=%b",
               obi.req, obi.addr, obi.be, exp.addr, exp.be);
    end
    obi.gnt = 1'b1;
    @(negedge clk);
    obi.gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obi.req !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got req=%b rv=%b ready=%b want 0 0 0", obi.req, rsp_valid, cmd_ready);
    end
    rst = 1'b0;
    obi.rvalid = 1'b1; obi.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    obi.rvalid = 1'b0; obi.rdata = '0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || obi.req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL late_rvalid: got rv=%b ready=%b req=%b want 0 1 0", rsp_valid, cmd_ready, obi.req);
    end
  endtask

`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
  task automatic test_timeout;
    int early;
    early = 0;
    rsp_q.push_back('{cfg: irq_line_t'(0), err: 1'b1});
    issue(1'b0, 6'd4, 1'b0, 1'b0, irq_line_t'(0));
    obi.gnt = 1'b1;
    @(negedge clk);
    obi.gnt = 1'b0;
    for (int i = 0; i < int'(TbTimeout); i++) begin
      if (rsp_valid !== 1'b0) early++;
      @(negedge clk);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got %0d early valid cycles want 0", early);
    end
    check_rsp(0);
  endtask
`endif

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_line = '0;
    cmd_wr_prio = 1'b0; cmd_wr_flags = 1'b0; cmd_cfg = '0; rsp_ready = 1'b0;
    obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.rdata = '0;
    test_reset();
    test_write_line6();
    test_read_line7();
    test_write_line3_prio();
    test_stall();
    test_skip_write();
    test_back_to_back();
    test_reset_mid();
`ifdef OBI_HETIC_CFG_MGR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
